hbm_channel_tester: RTL and testbench
=====================================

HBM_CHANNEL_TESTER -- requirements
Module: hbm_channel_tester

Interface
REQ-001 SHALL have parameter BASE_ADDR, 64'h0, byte address of the first burst; must be 512-byte aligned.
REQ-002 SHALL have parameter NUM_BURSTS, 1024, number of 16-beat bursts per pass; legal range 1..65535.
REQ-003 SHALL have port aclk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, run request; sampled only in IDLE.
REQ-006 SHALL have port busy, output, 1, high from the accepted start until DONE.
REQ-007 SHALL have port done, output, 1, high while in DONE.
REQ-008 SHALL have port pass, output, 1, valid with done; equals (err_count == 0).
REQ-009 SHALL have port err_count, output, 32, saturating error count for the current run.
REQ-010 SHALL have AXI3 master write-address ports: m_awaddr out 64, m_awlen out 4, m_awvalid out 1, m_awready in 1.
REQ-011 SHALL have AXI3 master write-data ports: m_wdata out 256, m_wstrb out 32, m_wlast out 1, m_wvalid out 1, m_wready in 1.
REQ-012 SHALL have AXI3 master write-response ports: m_bresp in 2, m_bvalid in 1, m_bready out 1.
REQ-013 SHALL have AXI3 master read-address ports: m_araddr out 64, m_arlen out 4, m_arvalid out 1, m_arready in 1.
REQ-014 SHALL have AXI3 master read-data ports: m_rdata in 256, m_rresp in 2, m_rlast in 1, m_rvalid in 1, m_rready out 1.
REQ-015 SHALL drive these constant outputs on both channels: m_awsize/m_arsize=3'b101, m_awburst/m_arburst=2'b01, and m_awlock/m_arlock, m_awcache/m_arcache, m_awprot/m_arprot, m_awqos/m_arqos all zero.

Function
REQ-016 SHALL implement FSM states IDLE, AW, W, B, AR, R, DONE with at most one outstanding transaction.
REQ-017 IDLE with start=1 SHALL clear err_count and the burst index n, then go to AW on the next edge.
REQ-018 Burst n SHALL use address BASE_ADDR + n*512 and awlen/arlen = 4'hF (16 beats of 32 bytes).
REQ-019 Beat k of burst n SHALL have beat address A = BASE_ADDR + n*512 + k*32, and 32-bit lane i (bits 32i+31:32i) SHALL equal A[31:0] + i, using modulo 2^32 arithmetic.
REQ-020 AW SHALL hold m_awvalid=1 with a stable address until m_awready, then go to W.
REQ-021 W SHALL drive m_wvalid=1 and m_wstrb=all ones, and advance a beat on each m_wvalid&&m_wready; m_wlast SHALL be 1 only on beat 15; the transfer of beat 15 SHALL go to B.
REQ-022 B SHALL drive m_bready=1; on m_bvalid, m_bresp!=0 SHALL add 1 error; then n++, and the FSM SHALL go to AW, or to AR with n=0 after the last burst.
REQ-023 AR SHALL hold m_arvalid=1 until m_arready, then go to R.
REQ-024 R SHALL drive m_rready=1; each accepted beat SHALL add 1 error if m_rresp!=0 or m_rdata != expected, counting at most 1 per beat.
REQ-025 In R, m_rlast on beat 15 SHALL end the burst; m_rlast early or missing on beat 15 SHALL add 1 error and end the burst at m_rlast.
REQ-026 After the last read burst the FSM SHALL go to DONE; DONE SHALL return to IDLE on the cycle after start=0 is sampled, so that a held start does not retrigger.
REQ-027 err_count SHALL saturate at 32'hFFFFFFFF.
REQ-028 valid outputs SHALL NOT drop before handshake completion, and payloads SHALL stay stable while valid and not ready.
REQ-029 All AXI outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-030 aresetn=0 SHALL asynchronously force IDLE and set busy, done, all valid signals, m_bready, m_rready, n, beat counter and err_count to 0; pass SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction without completing it; the slave must be reset together with this block.

Verification
REQ-032 Zero-wait memory model, NUM_BURSTS=2, start pulse -> 2 AW then 2 AR handshakes at 0x0 and 0x200, done=1, pass=1, err_count=0.
REQ-033 Model corrupts lane 3 of read beat 5 in burst 1 -> err_count=1, pass=0.
REQ-034 Random ready backpressure on all five channels -> payloads stable while stalled, result identical to REQ-032.
REQ-035 bresp=2'b10 on burst 0 plus rresp=2'b10 on one beat -> err_count=2.
REQ-036 aresetn pulsed low during W beat 7 -> all valids 0 immediately; a following start restarts from BASE_ADDR and passes.

Source files
------------

// File: rtl/hbm_channel_tester.sv
// AXI3 HBM channel tester: writes an address-derived pattern over NUM_BURSTS
// 16-beat bursts, reads it back and counts response/data errors.
module hbm_channel_tester #(
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int unsigned NUM_BURSTS = 1024
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [31:0]  err_count,
    output logic [63:0]  m_awaddr,
    output logic [3:0]   m_awlen,
    output logic [2:0]   m_awsize,
    output logic [1:0]   m_awburst,
    output logic [1:0]   m_awlock,
    output logic [3:0]   m_awcache,
    output logic [2:0]   m_awprot,
    output logic [3:0]   m_awqos,
    output logic         m_awvalid,
    input  logic         m_awready,
    output logic [255:0] m_wdata,
    output logic [31:0]  m_wstrb,
    output logic         m_wlast,
    output logic         m_wvalid,
    input  logic         m_wready,
    input  logic [1:0]   m_bresp,
    input  logic         m_bvalid,
    output logic         m_bready,
    output logic [63:0]  m_araddr,
    output logic [3:0]   m_arlen,
    output logic [2:0]   m_arsize,
    output logic [1:0]   m_arburst,
    output logic [1:0]   m_arlock,
    output logic [3:0]   m_arcache,
    output logic [2:0]   m_arprot,
    output logic [3:0]   m_arqos,
    output logic         m_arvalid,
    input  logic         m_arready,
    input  logic [255:0] m_rdata,
    input  logic [1:0]   m_rresp,
    input  logic         m_rlast,
    input  logic         m_rvalid,
    output logic         m_rready
);

    localparam logic [15:0] LAST_N = 16'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    function automatic logic [63:0] f_beat_addr(input logic [15:0] n, input logic [3:0] k);
        return BASE_ADDR + 64'(n) * 64'd512 + 64'(k) * 64'd32;
    endfunction

    function automatic logic [255:0] f_beat_data(input logic [63:0] addr);
        logic [255:0] d;
        d = 256'd0;
        for (int i = 0; i < 8; i++) begin
            d[32*i +: 32] = addr[31:0] + 32'(i);
        end
        return d;
    endfunction

    function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t         r_state, w_state_nx;
    logic [15:0]    r_n, w_n_nx;
    logic [3:0]     r_beat, w_beat_nx;
    logic [31:0]    r_err, w_err_nx;
    logic           r_busy, w_busy_nx;
    logic           r_done, w_done_nx;
    logic           r_pass, w_pass_nx;
    logic           r_awvalid, w_awvalid_nx;
    logic [63:0]    r_awaddr, w_awaddr_nx;
    logic           r_wvalid, w_wvalid_nx;
    logic           r_wlast, w_wlast_nx;
    logic [255:0]   r_wdata, w_wdata_nx;
    logic           r_bready, w_bready_nx;
    logic           r_arvalid, w_arvalid_nx;
    logic [63:0]    r_araddr, w_araddr_nx;
    logic           r_rready, w_rready_nx;
    logic [255:0]   w_exp_rdata;
    logic           w_beat_bad;

    assign w_exp_rdata = f_beat_data(f_beat_addr(r_n, r_beat));
    // rlast must coincide with beat 15; any deviation costs one error for this beat
    assign w_beat_bad  = (m_rresp != 2'b00) || (m_rdata != w_exp_rdata) ||
                         (m_rlast != (r_beat == 4'd15));

    // Next-state and next-output decode
    always_comb begin
        w_state_nx   = r_state;
        w_n_nx       = r_n;
        w_beat_nx    = r_beat;
        w_err_nx     = r_err;
        w_busy_nx    = r_busy;
        w_done_nx    = r_done;
        w_pass_nx    = r_pass;
        w_awvalid_nx = r_awvalid;
        w_awaddr_nx  = r_awaddr;
        w_wvalid_nx  = r_wvalid;
        w_wlast_nx   = r_wlast;
        w_wdata_nx   = r_wdata;
        w_bready_nx  = r_bready;
        w_arvalid_nx = r_arvalid;
        w_araddr_nx  = r_araddr;
        w_rready_nx  = r_rready;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx   = S_AW;
                    w_n_nx       = 16'd0;
                    w_beat_nx    = 4'd0;
                    w_err_nx     = 32'd0;
                    w_busy_nx    = 1'b1;
                    w_pass_nx    = 1'b0;
                    w_awvalid_nx = 1'b1;
                    w_awaddr_nx  = f_beat_addr(16'd0, 4'd0);
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_AW: begin
                if (m_awready) begin
                    w_state_nx   = S_W;
                    w_awvalid_nx = 1'b0;
                    w_wvalid_nx  = 1'b1;
                    w_wlast_nx   = 1'b0;
                    w_beat_nx    = 4'd0;
                    w_wdata_nx   = f_beat_data(f_beat_addr(r_n, 4'd0));
                end else begin
                    w_state_nx = S_AW;
                end
            end
            S_W: begin
                if (r_wvalid && m_wready) begin
                    if (r_beat == 4'd15) begin
                        w_state_nx  = S_B;
                        w_wvalid_nx = 1'b0;
                        w_wlast_nx  = 1'b0;
                        w_bready_nx = 1'b1;
                    end else begin
                        w_beat_nx  = r_beat + 4'd1;
                        w_wdata_nx = f_beat_data(f_beat_addr(r_n, r_beat + 4'd1));
                        w_wlast_nx = (r_beat == 4'd14);
                    end
                end else begin
                    w_state_nx = S_W;
                end
            end
            S_B: begin
                if (m_bvalid) begin
                    w_bready_nx = 1'b0;
                    if (m_bresp != 2'b00) begin
                        w_err_nx = f_sat_inc(r_err);
                    end else begin
                        w_err_nx = r_err;
                    end
                    if (r_n == LAST_N) begin
                        w_state_nx   = S_AR;
                        w_n_nx       = 16'd0;
                        w_arvalid_nx = 1'b1;
                        w_araddr_nx  = f_beat_addr(16'd0, 4'd0);
                    end else begin
                        w_state_nx   = S_AW;
                        w_n_nx       = r_n + 16'd1;
                        w_awvalid_nx = 1'b1;
                        w_awaddr_nx  = f_beat_addr(r_n + 16'd1, 4'd0);
                    end
                end else begin
                    w_state_nx = S_B;
                end
            end
            S_AR: begin
                if (m_arready) begin
                    w_state_nx   = S_R;
                    w_arvalid_nx = 1'b0;
                    w_rready_nx  = 1'b1;
                    w_beat_nx    = 4'd0;
                end else begin
                    w_state_nx = S_AR;
                end
            end
            S_R: begin
                if (m_rvalid) begin
                    if (w_beat_bad) begin
                        w_err_nx = f_sat_inc(r_err);
                    end else begin
                        w_err_nx = r_err;
                    end
                    // The slave's rlast, not our beat count, delimits the burst
                    if (m_rlast) begin
                        w_rready_nx = 1'b0;
                        if (r_n == LAST_N) begin
                            w_state_nx = S_DONE;
                            w_busy_nx  = 1'b0;
                            w_done_nx  = 1'b1;
                            w_pass_nx  = (w_err_nx == 32'd0);
                        end else begin
                            w_state_nx   = S_AR;
                            w_n_nx       = r_n + 16'd1;
                            w_arvalid_nx = 1'b1;
                            w_araddr_nx  = f_beat_addr(r_n + 16'd1, 4'd0);
                        end
                    end else if (r_beat != 4'd15) begin
                        w_beat_nx = r_beat + 4'd1;
                    end else begin
                        w_beat_nx = r_beat;
                    end
                end else begin
                    w_state_nx = S_R;
                end
            end
            S_DONE: begin
                if (!start) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b0;
                    w_pass_nx  = 1'b0;
                end else begin
                    w_state_nx = S_DONE;
                end
            end
            default: begin
                w_state_nx   = S_IDLE;
                w_busy_nx    = 1'b0;
                w_done_nx    = 1'b0;
                w_pass_nx    = 1'b0;
                w_awvalid_nx = 1'b0;
                w_wvalid_nx  = 1'b0;
                w_bready_nx  = 1'b0;
                w_arvalid_nx = 1'b0;
                w_rready_nx  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_n       <= 16'd0;
            r_beat    <= 4'd0;
            r_err     <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_awvalid <= 1'b0;
            r_awaddr  <= 64'd0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_wdata   <= 256'd0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_araddr  <= 64'd0;
            r_rready  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_n       <= w_n_nx;
            r_beat    <= w_beat_nx;
            r_err     <= w_err_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            r_pass    <= w_pass_nx;
            r_awvalid <= w_awvalid_nx;
            r_awaddr  <= w_awaddr_nx;
            r_wvalid  <= w_wvalid_nx;
            r_wlast   <= w_wlast_nx;
            r_wdata   <= w_wdata_nx;
            r_bready  <= w_bready_nx;
            r_arvalid <= w_arvalid_nx;
            r_araddr  <= w_araddr_nx;
            r_rready  <= w_rready_nx;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign m_awaddr  = r_awaddr;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = 32'hFFFF_FFFF;
    assign m_wlast   = r_wlast;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;
    assign m_araddr  = r_araddr;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;

    // Fixed INCR bursts of 32-byte beats, normal access
    assign m_awlen   = 4'hF;
    assign m_awsize  = 3'b101;
    assign m_awburst = 2'b01;
    assign m_awlock  = 2'b00;
    assign m_awcache = 4'h0;
    assign m_awprot  = 3'b000;
    assign m_awqos   = 4'h0;
    assign m_arlen   = 4'hF;
    assign m_arsize  = 3'b101;
    assign m_arburst = 2'b01;
    assign m_arlock  = 2'b00;
    assign m_arcache = 4'h0;
    assign m_arprot  = 3'b000;
    assign m_arqos   = 4'h0;

endmodule

// File: tb/tb_hbm_channel_tester.sv
// Bench for hbm_channel_tester: AXI3 memory slave model with optional random
// backpressure and fault injection, checked against an error-count model.
module tb_hbm_channel_tester;

    localparam logic [63:0] BASE = 64'h0;
    localparam int          NB   = 2;

    logic         aclk = 1'b0;
    logic         aresetn, start, busy, done, pass;
    logic [31:0]  err_count;
    logic [63:0]  m_awaddr, m_araddr;
    logic [3:0]   m_awlen, m_awcache, m_awqos, m_arlen, m_arcache, m_arqos;
    logic [2:0]   m_awsize, m_awprot, m_arsize, m_arprot;
    logic [1:0]   m_awburst, m_awlock, m_arburst, m_arlock;
    logic         m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic [255:0] m_wdata, m_rdata;
    logic [31:0]  m_wstrb;
    logic [1:0]   m_bresp, m_rresp;
    logic         m_bvalid, m_bready, m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

    hbm_channel_tester #(.BASE_ADDR(BASE), .NUM_BURSTS(NB)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arqos(m_arqos),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errs   = 0;

    // slave configuration and bookkeeping
    bit  bp;
    int  bad_b, cor_burst, cor_beat, cor_lane, rr_burst, rr_beat;
    int  aw_cnt, ar_cnt, wr_burst, wbeat, b_pending, b_cnt, r_pending, r_burst, rbeat;
    logic         s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr, s_wlast;
    logic [63:0]  s_awaddr, s_araddr;
    logic [255:0] s_wdata;
    logic [31:0]  s_wstrb;

    task automatic check_eq(input string tag, input logic [263:0] got, input logic [263:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_addr(input int b, input int k);
        return BASE + 64'(b) * 64'd512 + 64'(k) * 64'd32;
    endfunction

    function automatic logic [255:0] beat_data(input logic [63:0] a);
        logic [255:0] d;
        d = 256'd0;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = a[31:0] + 32'(i);
        return d;
    endfunction

    function automatic int expected_errors();
        int e = 0;
        if (bad_b >= 0 && bad_b < NB) e++;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 16; k++)
                if ((b == cor_burst && k == cor_beat) || (b == rr_burst && k == rr_beat)) e++;
        return e;
    endfunction

    // One slave step per falling edge: retire the handshakes of the last rising edge,
    // check stalled payloads, then choose new ready/valid values.
    task automatic slave_step();
        logic [255:0] d;
        if (!aresetn) begin
            aw_cnt = 0; ar_cnt = 0; wr_burst = 0; wbeat = 0; b_pending = 0; b_cnt = 0;
            r_pending = 0; r_burst = 0; rbeat = 0;
            m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
            m_bvalid = 1'b0; m_bresp = 2'b00;
            m_rvalid = 1'b0; m_rresp = 2'b00; m_rlast = 1'b0; m_rdata = 256'd0;
            s_awv = 1'b0; s_awr = 1'b0; s_wv = 1'b0; s_wr = 1'b0; s_bv = 1'b0; s_br = 1'b0;
            s_arv = 1'b0; s_arr = 1'b0; s_rv = 1'b0; s_rr = 1'b0;
        end else begin
            if (s_awv && s_awr) begin
                check_eq("aw_addr", {m_awlen, s_awaddr}, {4'hF, beat_addr(aw_cnt, 0)});
                aw_cnt++;
            end else if (s_awv) begin
                check_eq("aw_hold", {m_awvalid, m_awaddr}, {1'b1, s_awaddr});
            end
            if (s_wv && s_wr) begin
                check_eq("w_data", s_wdata, beat_data(beat_addr(wr_burst, wbeat)));
                check_eq("w_last_strb", {s_wlast, s_wstrb}, {(wbeat == 15), 32'hFFFF_FFFF});
                if (wbeat == 15) begin
                    wbeat = 0; wr_burst++; b_pending++;
                end else begin
                    wbeat++;
                end
            end else if (s_wv) begin
                check_eq("w_hold", {m_wvalid, m_wlast, m_wdata}, {1'b1, s_wlast, s_wdata});
            end
            if (s_bv && s_br) begin
                b_cnt++; m_bvalid = 1'b0; m_bresp = 2'b00;
            end
            if (!m_bvalid && b_pending > 0 && (!bp || $urandom_range(0, 2) == 0)) begin
                m_bvalid = 1'b1;
                m_bresp  = (b_cnt == bad_b) ? 2'b10 : 2'b00;
                b_pending--;
            end
            if (s_arv && s_arr) begin
                check_eq("ar_addr", {m_arlen, s_araddr}, {4'hF, beat_addr(ar_cnt, 0)});
                ar_cnt++; r_pending++;
            end else if (s_arv) begin
                check_eq("ar_hold", {m_arvalid, m_araddr}, {1'b1, s_araddr});
            end
            if (s_rv && s_rr) begin
                m_rvalid = 1'b0;
                if (rbeat == 15) begin
                    rbeat = 0; r_burst++; r_pending--;
                end else begin
                    rbeat++;
                end
            end
            if (!m_rvalid && r_pending > 0 && (!bp || $urandom_range(0, 2) == 0)) begin
                d = beat_data(beat_addr(r_burst, rbeat));
                if (r_burst == cor_burst && rbeat == cor_beat)
                    d[32*cor_lane +: 32] = d[32*cor_lane +: 32] ^ 32'h0000_0100;
                m_rdata  = d;
                m_rresp  = (r_burst == rr_burst && rbeat == rr_beat) ? 2'b10 : 2'b00;
                m_rlast  = (rbeat == 15);
                m_rvalid = 1'b1;
            end
            m_awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m_wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m_arready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            s_awv = m_awvalid; s_awr = m_awready; s_awaddr = m_awaddr;
            s_wv = m_wvalid; s_wr = m_wready; s_wdata = m_wdata; s_wlast = m_wlast; s_wstrb = m_wstrb;
            s_bv = m_bvalid; s_br = m_bready;
            s_arv = m_arvalid; s_arr = m_arready; s_araddr = m_araddr;
            s_rv = m_rvalid; s_rr = m_rready;
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        slave_step();
    endtask

    task automatic run_pass(input string nm, input bit bp_i, input int bb, input int cb,
                            input int ck, input int cl, input int rb, input int rk);
        int exp_err;
        bit fin;
        bp = bp_i; bad_b = bb; cor_burst = cb; cor_beat = ck; cor_lane = cl;
        rr_burst = rb; rr_beat = rk;
        exp_err = expected_errors();
        aresetn = 1'b0; start = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
        start = 1'b1;
        tick();
        check_eq({nm, "_launch"}, {busy, m_awvalid, m_awaddr}, {1'b1, 1'b1, BASE});
        fin = 1'b0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            tick();
            fin = done;
        end
        check_eq({nm, "_finished"}, fin, 1'b1);
        check_eq({nm, "_result"}, {busy, pass, err_count}, {1'b0, (exp_err == 0), 32'(exp_err)});
        check_eq({nm, "_counts"}, {16'(aw_cnt), 16'(wr_burst), 16'(ar_cnt), 16'(r_burst)},
                 {16'(NB), 16'(NB), 16'(NB), 16'(NB)});
        repeat (3) tick();
        check_eq({nm, "_held_start"}, {done, busy, err_count}, {1'b1, 1'b0, 32'(exp_err)});
        start = 1'b0;
        tick();
        check_eq({nm, "_to_idle"}, {done, busy, pass}, 3'b000);
        repeat (2) tick();
        check_eq({nm, "_idle_quiet"}, {busy, m_awvalid, m_arvalid}, 3'b000);
    endtask

    initial begin
        bit fin;
        aresetn = 1'b0; start = 1'b0; bp = 1'b0;
        bad_b = -1; cor_burst = -1; cor_beat = 0; cor_lane = 0; rr_burst = -1; rr_beat = 0;
        repeat (2) tick();
        check_eq("reset_outputs",
                 {busy, done, pass, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, err_count},
                 40'd0);
        check_eq("const_outputs",
                 {m_awsize, m_arsize, m_awburst, m_arburst, m_awlock, m_arlock,
                  m_awcache, m_arcache, m_awprot, m_arprot, m_awqos, m_arqos},
                 {3'b101, 3'b101, 2'b01, 2'b01, 26'd0});

        run_pass("zero_wait", 1'b0, -1, -1, 0, 0, -1, 0);
        run_pass("corrupt_l3b5", 1'b0, -1, 1, 5, 3, -1, 0);
        run_pass("backpressure", 1'b1, -1, -1, 0, 0, -1, 0);
        run_pass("resp_errors", 1'b1, 0, -1, 0, 0, $urandom_range(0, NB - 1), $urandom_range(0, 15));
        for (int i = 0; i < 3; i++) begin
            run_pass("random_faults", 1'($urandom_range(0, 1)), $urandom_range(0, 3) - 1,
                     $urandom_range(0, NB - 1), $urandom_range(0, 15), $urandom_range(0, 7),
                     $urandom_range(0, NB - 1), $urandom_range(0, 15));
        end

        // abandon a write burst while beat 7 is on the bus
        bp = 1'b0; bad_b = -1; cor_burst = -1; rr_burst = -1;
        aresetn = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
        start = 1'b1;
        fin = 1'b0;
        for (int c = 0; c < 500 && !fin; c++) begin
            tick();
            fin = (wbeat == 7 && wr_burst == 0 && m_wvalid);
        end
        check_eq("reach_w_beat7", fin, 1'b1);
        aresetn = 1'b0;
        #1;
        check_eq("async_reset_valids",
                 {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, busy, done, err_count},
                 39'd0);
        start = 1'b0;
        run_pass("restart", 1'b0, -1, -1, 0, 0, -1, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
